// File: rtl/mem_stage_pkg.sv
// Shared widths, write-back select codes and memory FSM encoding for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int GPR_WIDTH      = 32;
  localparam int GPR_ADDR_WIDTH = 5;
  localparam int PC_WIDTH       = 16;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC   = 2'b10,
    WB_SEL_IMM  = 2'b11
  } wb_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_stage_branch_unit.sv
// Combinational branch decision: ALU-zero compare for beq/bne, flag-register test for jt/jf.
module branch_unit (
  input  logic       alu_zero_i,
  input  logic [1:0] flags_i,
  input  logic       flag_sel_i,
  input  logic       sel_beq_bne_i,
  input  logic       sel_jt_jf_i,
  input  logic       sel_jflag_i,
  output logic       taken_o
);

  always_comb begin
    taken_o = 1'b0;
    if (sel_jflag_i) begin
      taken_o = flags_i[flag_sel_i] ^ sel_jt_jf_i;
    end else begin
      taken_o = alu_zero_i ^ sel_beq_bne_i;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory handshake, flag register, branch resolution and MEM/WB register.
//   state   | meaning
//   IDLE    | no access outstanding; request driven straight from EX/MEM inputs
//   WAIT    | access issued but not yet acknowledged; request replayed from latched copy
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = GPR_WIDTH,
  parameter int RADDR_W = GPR_ADDR_WIDTH,
  parameter int PC_W    = PC_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_alu_data,
  input  logic [1:0]         in_alu_flags,
  input  logic [DATA_W-1:0]  in_data_rt,
  input  logic [RADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0]  in_branch_target,
  input  logic [PC_W-1:0]    in_next_pc,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic               in_mem_write_enable,
  input  logic               in_sel_beq_bne,
  input  logic               in_sel_jt_jf,
  input  logic               in_is_branch,
  input  logic               in_sel_jflag_branch,
  input  logic               in_fl_write_enable,
  input  logic [1:0]         in_wb_res_mux,
  input  logic               in_reg_write_enable,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ready,
  output logic               stall,
  output logic [1:0]         flags,
  output logic               out_branch_taken,
  output logic [PC_W-1:0]    out_branch_target,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_alu_data,
  output logic [DATA_W-1:0]  out_mem_data,
  output logic [PC_W-1:0]    out_next_pc,
  output logic [DATA_W-1:0]  out_imm,
  output logic [RADDR_W-1:0] out_dest,
  output logic [1:0]         out_wb_res_mux,
  output logic               out_reg_write_enable
);

  mem_state_e        state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;

  logic [1:0]         flags_q;
  logic               br_taken_q;
  logic [PC_W-1:0]    br_target_q;
  logic               out_valid_q;
  logic [DATA_W-1:0]  out_alu_q;
  logic [DATA_W-1:0]  out_mem_q;
  logic [PC_W-1:0]    out_npc_q;
  logic [DATA_W-1:0]  out_imm_q;
  logic [RADDR_W-1:0] out_dest_q;
  logic [1:0]         out_wb_q;
  logic               out_rwe_q;

  logic is_load, is_mem, accept, br_taken;

  // Branch target is only PC_W wide; the upper adder bits are intentionally dropped.
  logic unused_target_hi;
  assign unused_target_hi = ^in_branch_target[DATA_W-1:PC_W];

  assign is_load = (in_wb_res_mux == WB_SEL_LOAD);
  assign is_mem  = in_valid & (in_mem_write_enable | is_load);
  assign accept  = in_valid & ~stall;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = in_alu_data;
    dmem_wdata = in_data_rt;
    stall      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dmem_req = is_mem;
        dmem_we  = is_mem & in_mem_write_enable;
        stall    = is_mem & ~dmem_ready;
        if (is_mem && !dmem_ready) begin
          state_d = ST_WAIT;
          addr_d  = in_alu_data;
          wdata_d = in_data_rt;
          we_d    = in_mem_write_enable;
        end
      end
      ST_WAIT: begin
        dmem_req   = 1'b1;
        dmem_we    = we_q;
        dmem_addr  = addr_q;
        dmem_wdata = wdata_q;
        stall      = ~dmem_ready;
        if (dmem_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sees the flag register before this cycle's write, so a write followed by jt/jf uses the new value.
  branch_unit u_branch (
    .alu_zero_i    (in_alu_flags[0]),
    .flags_i       (flags_q),
    .flag_sel_i    (in_imm[0]),
    .sel_beq_bne_i (in_sel_beq_bne),
    .sel_jt_jf_i   (in_sel_jt_jf),
    .sel_jflag_i   (in_sel_jflag_branch),
    .taken_o       (br_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      flags_q     <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      out_valid_q <= 1'b0;
      out_alu_q   <= '0;
      out_mem_q   <= '0;
      out_npc_q   <= '0;
      out_imm_q   <= '0;
      out_dest_q  <= '0;
      out_wb_q    <= '0;
      out_rwe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      out_valid_q <= accept;
      out_rwe_q   <= accept & in_reg_write_enable & ~in_mem_write_enable;
      br_taken_q  <= accept & in_is_branch & br_taken;
      if (accept) begin
        out_alu_q  <= in_alu_data;
        out_npc_q  <= in_next_pc;
        out_imm_q  <= in_imm;
        out_dest_q <= in_dest;
        out_wb_q   <= in_wb_res_mux;
      end
      if (accept && is_load) begin
        out_mem_q <= dmem_rdata;
      end
      if (accept && in_fl_write_enable) begin
        flags_q <= in_alu_flags;
      end
      if (accept && in_is_branch) begin
        br_target_q <= in_branch_target[PC_W-1:0];
      end
    end
  end

  assign flags                = flags_q;
  assign out_branch_taken     = br_taken_q;
  assign out_branch_target    = br_target_q;
  assign out_valid            = out_valid_q;
  assign out_alu_data         = out_alu_q;
  assign out_mem_data         = out_mem_q;
  assign out_next_pc          = out_npc_q;
  assign out_imm              = out_imm_q;
  assign out_dest             = out_dest_q;
  assign out_wb_res_mux       = out_wb_q;
  assign out_reg_write_enable = out_rwe_q;

endmodule
